wb_conbus_gnt_ctrl: RTL and testbench

Weighted round-robin grant controller for the shared Wishbone interconnect (conbus). It replaces the plain park-on-last arbiter with three additions: per-master beat quotas, a bus-timeout watchdog and an explicit one-cycle hand-off between owners. Its outputs (`gnt`, `gnt_vld`) drive the conbus master/slave muxes. `preempt_o` and `to_err_o` are ORed into the granted master's `rty_i` and `err_i` respectively.

---
 rtl/wb_conbus_gnt_ctrl.sv | 124 ++++++++++++
 tb/tb_wb_conbus_gnt_ctrl.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/wb_conbus_gnt_ctrl.sv
// Weighted round-robin grant controller for the Wishbone conbus.
// Adds per-master beat quotas, a bus watchdog and a one-cycle hand-off between owners.
module wb_conbus_gnt_ctrl #(
   parameter int N_MST = 8,
   parameter int GW    = 3,
   parameter int QW    = 4,
   parameter int TOW   = 8
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic [N_MST-1:0]    req,
   input  logic                ack_i,
   input  logic [N_MST*QW-1:0] quota_i,
   input  logic [TOW-1:0]      to_limit_i,
   output logic [GW-1:0]       gnt,
   output logic [N_MST-1:0]    gnt_oh,
   output logic                gnt_vld,
   output logic                preempt_o,
   output logic                to_err_o
);

   typedef enum logic [1:0] {IDLE, GRANT, HANDOFF} state_t;

   state_t           state;
   logic [QW-1:0]    qcnt;
   logic [TOW-1:0]   tocnt;

   logic [GW-1:0]    pick;
   logic [N_MST-1:0] pick_oh;
   logic [N_MST-1:0] own_oh;
   logic [QW-1:0]    pick_quota;
   logic [QW-1:0]    cur_quota;
   logic [TOW-1:0]   tocnt_inc;
   logic             any_req;
   logic             others;
   logic             own_req;
   logic             q_hit;
   logic             to_hit;

   // Scan downward so the nearest requester after the current owner wins; the owner itself is last.
   always_comb begin
      int idx;
      idx  = 0;
      pick = gnt;
      for (int i = N_MST; i >= 1; i--) begin
         idx = (int'(gnt) + i) % N_MST;
         if (req[idx]) pick = GW'(idx);
      end
   end

   always_comb begin
      pick_oh    = N_MST'(1) << pick;
      own_oh     = N_MST'(1) << gnt;
      pick_quota = quota_i[pick*QW +: QW];
      cur_quota  = quota_i[gnt*QW +: QW];
      tocnt_inc  = tocnt + TOW'(1);
      any_req    = |req;
      others     = |(req & ~own_oh);
      own_req    = req[gnt];
      q_hit      = ack_i && (qcnt != '0) && (qcnt == QW'(1)) && others;
      to_hit     = !ack_i && (to_limit_i != '0) && (tocnt_inc == to_limit_i);
   end

   // A zero qcnt means unlimited ownership, so it is never decremented.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= IDLE;
         gnt       <= '0;
         gnt_oh    <= '0;
         gnt_vld   <= 1'b0;
         preempt_o <= 1'b0;
         to_err_o  <= 1'b0;
         qcnt      <= '0;
         tocnt     <= '0;
      end else begin
         preempt_o <= 1'b0;
         to_err_o  <= 1'b0;
         case (state)
            IDLE, HANDOFF: begin
               if (any_req) begin
                  state   <= GRANT;
                  gnt     <= pick;
                  gnt_oh  <= pick_oh;
                  gnt_vld <= 1'b1;
                  qcnt    <= pick_quota;
                  tocnt   <= '0;
               end else begin
                  state   <= IDLE;
                  gnt_oh  <= '0;
                  gnt_vld <= 1'b0;
               end
            end
            GRANT: begin
               if (!own_req) begin
                  state   <= HANDOFF;
                  gnt_oh  <= '0;
                  gnt_vld <= 1'b0;
               end else if (q_hit) begin
                  state     <= HANDOFF;
                  gnt_oh    <= '0;
                  gnt_vld   <= 1'b0;
                  preempt_o <= 1'b1;
               end else if (to_hit) begin
                  state    <= HANDOFF;
                  gnt_oh   <= '0;
                  gnt_vld  <= 1'b0;
                  to_err_o <= 1'b1;
               end else if (ack_i) begin
                  tocnt <= '0;
                  if (qcnt != '0) qcnt <= (qcnt == QW'(1)) ? cur_quota : qcnt - QW'(1);
               end else if (tocnt != '1) begin
                  tocnt <= tocnt_inc;
               end
            end
            default: begin
               state   <= IDLE;
               gnt_oh  <= '0;
               gnt_vld <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_wb_conbus_gnt_ctrl.sv
// Directed bench for wb_conbus_gnt_ctrl: reset, round robin, quota, watchdog, priority, async reset.
module tb_wb_conbus_gnt_ctrl;

   logic        clk = 1'b0;
   logic        rst_n = 1'b1;
   logic [7:0]  req = '0;
   logic        ack_i = 1'b0;
   logic [31:0] quota_i = '0;
   logic [7:0]  to_limit_i = '0;
   logic [2:0]  gnt;
   logic [7:0]  gnt_oh;
   logic        gnt_vld;
   logic        preempt_o;
   logic        to_err_o;

   int vectors = 0;
   int miscompares = 0;
   logic [13:0] e;

   wb_conbus_gnt_ctrl #(.N_MST(8), .GW(3), .QW(4), .TOW(8)) dut (
      .clk(clk), .rst_n(rst_n), .req(req), .ack_i(ack_i), .quota_i(quota_i),
      .to_limit_i(to_limit_i), .gnt(gnt), .gnt_oh(gnt_oh), .gnt_vld(gnt_vld),
      .preempt_o(preempt_o), .to_err_o(to_err_o)
   );

   always #5 clk = ~clk;

   function automatic logic [13:0] obs();
      obs = {gnt_vld, gnt, gnt_oh, preempt_o, to_err_o};
   endfunction

   function automatic logic [13:0] ex(input logic v, input logic [2:0] g, input logic p, input logic t);
      ex = {v, g, (v ? (8'd1 << g) : 8'd0), p, t};
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      #2 rst_n = 1'b0;
      #1;
      e = ex(1'b0, 3'd0, 1'b0, 1'b0);
      vectors++; if (obs() !== e) begin miscompares++; $display("[TB] FAIL reset_values got=%h exp=%h", obs(), e); end
      tick();
      rst_n = 1'b1;
   endtask

   task automatic test_basic();
      req = 8'h01;
      tick();
      e = ex(1'b1, 3'd0, 1'b0, 1'b0);
      vectors++; if (obs() !== e) begin miscompares++; $display("[TB] FAIL basic_grant got=%h exp=%h", obs(), e); end
      req = 8'h00;
      tick();
      e = ex(1'b0, 3'd0, 1'b0, 1'b0);
      vectors++; if (obs() !== e) begin miscompares++; $display("[TB] FAIL basic_handoff got=%h exp=%h", obs(), e); end
      tick();
      vectors++; if (obs() !== e) begin miscompares++; $display("[TB] FAIL basic_idle got=%h exp=%h", obs(), e); end
   endtask

   task automatic test_round_robin();
      req = 8'h04;
      tick();
      e = ex(1'b1, 3'd2, 1'b0, 1'b0);
      vectors++; if (obs() !== e) begin miscompares++; $display("[TB] FAIL rr_gnt2 got=%h exp=%h", obs(), e); end
      req = 8'h85;
      tick();
      vectors++; if (obs() !== e) begin miscompares++; $display("[TB] FAIL rr_hold2 got=%h exp=%h", obs(), e); end
      req = 8'h81;
      tick();
      e = ex(1'b0, 3'd2, 1'b0, 1'b0);
      vectors++; if (obs() !== e) begin miscompares++; $display("[TB] FAIL rr_handoff2 got=%h exp=%h", obs(), e); end
      tick();
      e = ex(1'b1, 3'd7, 1'b0, 1'b0);
      vectors++; if (obs() !== e) begin miscompares++; $display("[TB] FAIL rr_gnt7 got=%h exp=%h", obs(), e); end
      req = 8'h01;
      tick();
      e = ex(1'b0, 3'd7, 1'b0, 1'b0);
      vectors++; if (obs() !== e) begin miscompares++; $display("[TB] FAIL rr_handoff7 got=%h exp=%h", obs(), e); end
      tick();
      e = ex(1'b1, 3'd0, 1'b0, 1'b0);
      vectors++; if (obs() !== e) begin miscompares++; $display("[TB] FAIL rr_wrap0 got=%h exp=%h", obs(), e); end
      req = 8'h00;
      tick();
      tick();
      e = ex(1'b0, 3'd0, 1'b0, 1'b0);
      vectors++; if (obs() !== e) begin miscompares++; $display("[TB] FAIL rr_idle got=%h exp=%h", obs(), e); end
   endtask

   task automatic test_quota();
      quota_i = 32'h0000_0030;
      req = 8'h0A;
      tick();
      e = ex(1'b1, 3'd1, 1'b0, 1'b0);
      vectors++; if (obs() !== e) begin miscompares++; $display("[TB] FAIL quota_gnt1 got=%h exp=%h", obs(), e); end
      ack_i = 1'b1;
      for (int i = 1; i <= 2; i++) begin
         tick();
         vectors++; if (obs() !== e) begin miscompares++; $display("[TB] FAIL quota_beat%0d got=%h exp=%h", i, obs(), e); end
      end
      tick();
      e = ex(1'b0, 3'd1, 1'b1, 1'b0);
      vectors++; if (obs() !== e) begin miscompares++; $display("[TB] FAIL quota_preempt got=%h exp=%h", obs(), e); end
      tick();
      e = ex(1'b1, 3'd3, 1'b0, 1'b0);
      vectors++; if (obs() !== e) begin miscompares++; $display("[TB] FAIL quota_next3 got=%h exp=%h", obs(), e); end
      ack_i = 1'b0;
      req = 8'h00;
      tick();
      tick();
      req = 8'h02;
      tick();
      e = ex(1'b1, 3'd1, 1'b0, 1'b0);
      vectors++; if (obs() !== e) begin miscompares++; $display("[TB] FAIL quota_solo_gnt got=%h exp=%h", obs(), e); end
      ack_i = 1'b1;
      for (int i = 1; i <= 7; i++) begin
         tick();
         vectors++; if (obs() !== e) begin miscompares++; $display("[TB] FAIL quota_solo_keep%0d got=%h exp=%h", i, obs(), e); end
      end
      ack_i = 1'b0;
      req = 8'h00;
      tick();
      tick();
      quota_i = '0;
   endtask

   task automatic test_timeout();
      to_limit_i = 8'd5;
      req = 8'h10;
      tick();
      e = ex(1'b1, 3'd4, 1'b0, 1'b0);
      vectors++; if (obs() !== e) begin miscompares++; $display("[TB] FAIL to_gnt4 got=%h exp=%h", obs(), e); end
      for (int i = 1; i <= 4; i++) begin
         tick();
         vectors++; if (obs() !== e) begin miscompares++; $display("[TB] FAIL to_wait%0d got=%h exp=%h", i, obs(), e); end
      end
      tick();
      e = ex(1'b0, 3'd4, 1'b0, 1'b1);
      vectors++; if (obs() !== e) begin miscompares++; $display("[TB] FAIL to_err_pulse got=%h exp=%h", obs(), e); end
      to_limit_i = 8'd0;
      tick();
      e = ex(1'b1, 3'd4, 1'b0, 1'b0);
      vectors++; if (obs() !== e) begin miscompares++; $display("[TB] FAIL to_regrant got=%h exp=%h", obs(), e); end
      for (int i = 1; i <= 300; i++) begin
         tick();
         if (obs() !== e) begin
            vectors++; miscompares++;
            $display("[TB] FAIL to_disabled cycle%0d got=%h exp=%h", i, obs(), e);
            break;
         end
      end
      vectors++;
      req = 8'h00;
      tick();
      tick();
   endtask

   task automatic test_simultaneous();
      quota_i = 32'h0020_0000;
      req = 8'h20;
      tick();
      e = ex(1'b1, 3'd5, 1'b0, 1'b0);
      vectors++; if (obs() !== e) begin miscompares++; $display("[TB] FAIL sim_gnt5 got=%h exp=%h", obs(), e); end
      req = 8'h21;
      ack_i = 1'b1;
      tick();
      vectors++; if (obs() !== e) begin miscompares++; $display("[TB] FAIL sim_beat1 got=%h exp=%h", obs(), e); end
      req = 8'h01;
      tick();
      e = ex(1'b0, 3'd5, 1'b0, 1'b0);
      vectors++; if (obs() !== e) begin miscompares++; $display("[TB] FAIL sim_drop_wins got=%h exp=%h", obs(), e); end
      ack_i = 1'b0;
      tick();
      e = ex(1'b1, 3'd0, 1'b0, 1'b0);
      vectors++; if (obs() !== e) begin miscompares++; $display("[TB] FAIL sim_next0 got=%h exp=%h", obs(), e); end
      req = 8'h00;
      quota_i = '0;
      tick();
      tick();
   endtask

   task automatic test_reset_mid_grant();
      req = 8'h40;
      tick();
      e = ex(1'b1, 3'd6, 1'b0, 1'b0);
      vectors++; if (obs() !== e) begin miscompares++; $display("[TB] FAIL rst_gnt6 got=%h exp=%h", obs(), e); end
      tick();
      tick();
      tick();
      #2 rst_n = 1'b0;
      #1;
      e = ex(1'b0, 3'd0, 1'b0, 1'b0);
      vectors++; if (obs() !== e) begin miscompares++; $display("[TB] FAIL rst_async got=%h exp=%h", obs(), e); end
      req = 8'h48;
      tick();
      vectors++; if (obs() !== e) begin miscompares++; $display("[TB] FAIL rst_held got=%h exp=%h", obs(), e); end
      rst_n = 1'b1;
      tick();
      e = ex(1'b1, 3'd3, 1'b0, 1'b0);
      vectors++; if (obs() !== e) begin miscompares++; $display("[TB] FAIL rst_first_pick got=%h exp=%h", obs(), e); end
      req = 8'h00;
      tick();
   endtask

   initial begin
      test_reset();
      test_basic();
      test_round_robin();
      test_quota();
      test_timeout();
      test_simultaneous();
      test_reset_mid_grant();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
